// File: rtl/bg_scroll_ctrl_if.sv
// rtl/bg_scroll_ctrl_if.sv - raster-in / ROM-address-out signal bundle for bg_scroll_ctrl
interface bg_scroll_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int OFF_W  = 7
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic [9:0]        p1_x;
    logic [9:0]        p2_x;
    logic              scroll_en;
    logic [ADDR_W-1:0] rom_address;
    logic              addr_valid;
    logic [OFF_W-1:0]  scroll_x;
    logic              frame_done;

    modport master (
        output DrawX, DrawY, blank, p1_x, p2_x, scroll_en,
        input  rom_address, addr_valid, scroll_x, frame_done
    );

    modport slave (
        input  DrawX, DrawY, blank, p1_x, p2_x, scroll_en,
        output rom_address, addr_valid, scroll_x, frame_done
    );
endinterface

// File: rtl/bg_scroll_ctrl.sv
// rtl/bg_scroll_ctrl.sv - background ROM address sequencer with vblank-only camera scroll
module bg_scroll_ctrl #(
    parameter int IMG_W   = 712,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int STEP    = 4,
    parameter int ADDR_W  = 19,
    parameter int OFF_W   = 7
) (
    input  logic           vga_clk,
    input  logic           reset_n,
    bg_scroll_ctrl_if.slave bus
);

    localparam logic [9:0]        X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]        Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]        Y_VBS     = 10'(SCR_H);
    localparam logic [9:0]        Y_ROW_END = 10'(SCR_H - 1);
    localparam logic [9:0]        P_MAX     = 10'(IMG_W - 1);
    localparam logic [9:0]        HALF      = 10'(SCR_W / 2);
    localparam logic [9:0]        OFF_MAX10 = 10'(IMG_W - SCR_W);
    localparam logic [OFF_W-1:0]  OFF_MAX   = OFF_W'(IMG_W - SCR_W);
    localparam logic [OFF_W-1:0]  STEP_V    = OFF_W'(STEP);
    localparam logic [ADDR_W-1:0] PITCH     = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {S_SYNC, S_RUN, S_CALC, S_MOVE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [9:0]        p1_q, p1_d, p2_q, p2_d;
    logic [OFF_W-1:0]  target_q, target_d;
    logic [OFF_W-1:0]  scroll_q, scroll_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic              eof, vbs;
    logic [10:0]       sum;
    logic [9:0]        mid, t;
    logic [OFF_W-1:0]  diff, delta;

    assign eof = (bus.DrawX == X_LAST) && (bus.DrawY == Y_LAST);
    assign vbs = (bus.DrawX == 10'd0) && (bus.DrawY == Y_VBS);

    // Camera target: fighters' midpoint centred on screen, clamped into the image
    assign sum   = {1'b0, p1_q} + {1'b0, p2_q};
    assign mid   = 10'(sum >> 1);
    assign t     = (mid < HALF) ? 10'd0 : mid - HALF;
    assign diff  = (target_q > scroll_q) ? target_q - scroll_q : scroll_q - target_q;
    assign delta = (diff > STEP_V) ? STEP_V : diff;

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        p1_d       = p1_q;
        p2_d       = p2_q;
        target_d   = target_q;
        scroll_d   = scroll_q;
        done_d     = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (eof) begin
                    row_base_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (vbs) begin
                    p1_d    = (bus.p1_x > P_MAX) ? P_MAX : bus.p1_x;
                    p2_d    = (bus.p2_x > P_MAX) ? P_MAX : bus.p2_x;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                target_d = (t > OFF_MAX10) ? OFF_MAX : t[OFF_W-1:0];
                state_d  = S_MOVE;
            end
            S_MOVE: begin
                done_d = 1'b1;
                if (bus.scroll_en) begin
                    scroll_d = (target_q > scroll_q) ? scroll_q + delta : scroll_q - delta;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eof) state_d = S_RUN;
            end
            default: state_d = S_SYNC;
        endcase

        // Row base tracks y*IMG_W incrementally; it parks on the last visible row through vblank
        if (state_q != S_SYNC && bus.DrawX == X_LAST) begin
            if (bus.DrawY == Y_LAST)
                row_base_d = '0;
            else if (bus.DrawY < Y_ROW_END)
                row_base_d = row_base_q + PITCH;
        end
    end

    assign addr_d  = row_base_q + ADDR_W'(scroll_q) + ADDR_W'(bus.DrawX);
    assign valid_d = bus.blank && (state_q != S_SYNC);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_SYNC;
            row_base_q <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            target_q   <= '0;
            scroll_q   <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            target_q   <= target_d;
            scroll_q   <= scroll_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_address = addr_q;
    assign bus.addr_valid  = valid_q;
    assign bus.scroll_x    = scroll_q;
    assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// tb/tb_bg_scroll_ctrl.sv - randomized sparse-raster bench with behavioural camera/address model
module tb_bg_scroll_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bg_scroll_ctrl_if #(.ADDR_W(19), .OFF_W(7)) bus();

    bg_scroll_ctrl #(
        .IMG_W(712), .SCR_W(640), .SCR_H(480), .H_TOTAL(800), .V_TOTAL(525),
        .STEP(4), .ADDR_W(19), .OFF_W(7)
    ) dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: what the camera and row pointer must be, from the frame rules
    bit    m_chk = 0;
    bit    m_synced = 0;
    bit    m_armed = 0;
    int    m_scroll = 0;
    int    m_target = 0;
    int    m_cd = 0;
    int    m_rb = 0;
    int    frame_no = -1;

    bit    exp_valid, exp_done, exp_addr_chk;
    int    exp_addr, exp_scroll;
    bit    lit_on;
    int    lit_val;
    string lit_name;
    int    fd_cnt = 0;

    int exp_tbl [0:22] = '{4, 8, 12, 16, 20, 24, 28, 30,
                           30, 30, 30,
                           34, 38, 42, 46, 50, 54, 58, 62, 66, 70, 72,
                           68};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (frame %0d, t=%0t)", name, act, exp, frame_no, $time);
        end
    endtask

    function automatic int target_of(input int a, input int b);
        int ca, cb, mid, t;
        ca  = (a > 711) ? 711 : a;
        cb  = (b > 711) ? 711 : b;
        mid = (ca + cb) / 2;
        t   = (mid < 320) ? 0 : mid - 320;
        return (t > 72) ? 72 : t;
    endfunction

    task automatic step(input int x, input int y, input bit bl);
        int d;
        @(negedge clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = bl;

        exp_valid    = bl && m_synced;
        exp_addr_chk = m_synced;
        exp_addr     = m_rb + m_scroll + x;

        lit_on = 0;
        if (m_synced && x == 0 && y == 0 && frame_no == 0) begin
            lit_on = 1; lit_val = 0; lit_name = "first_pixel_addr";
        end
        if (m_synced && x == 5 && y == 1 && m_scroll == 20) begin
            lit_on = 1; lit_val = 737; lit_name = "pixel_5_1_scroll20";
        end
        if (m_synced && x == 639 && y == 479 && m_scroll == 72) begin
            lit_on = 1; lit_val = 341759; lit_name = "worst_case_addr";
        end

        exp_done = 0;
        if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                exp_done = 1;
                if (bus.scroll_en) begin
                    d = (m_target > m_scroll) ? m_target - m_scroll : m_scroll - m_target;
                    if (d > 4) d = 4;
                    m_scroll = (m_target > m_scroll) ? m_scroll + d : m_scroll - d;
                end
            end
        end

        if (m_synced) begin
            if (x == 799) begin
                if (y == 524)      m_rb = 0;
                else if (y < 479)  m_rb = (y + 1) * 712;
            end
            if (x == 799 && y == 524) m_armed = 1;
            if (x == 0 && y == 480 && m_armed) begin
                m_armed  = 0;
                m_target = target_of(int'(bus.p1_x), int'(bus.p2_x));
                m_cd     = 2;
            end
        end else if (x == 799 && y == 524) begin
            m_synced = 1;
            m_armed  = 1;
            m_rb     = 0;
        end
        exp_scroll = m_scroll;
    endtask

    task automatic run_line(input int y);
        int x1;
        if (y < 480) begin
            x1 = (y == 1) ? 5 : int'($urandom_range(1, 638));
            step(0,   y, $urandom_range(0, 15) != 0);
            step(x1,  y, $urandom_range(0, 15) != 0);
            step(639, y, $urandom_range(0, 15) != 0);
            step(799, y, 1'b0);
        end else begin
            step(0,   y, 1'b0);
            step(799, y, 1'b0);
            if (y >= 482 && $urandom_range(0, 7) == 0) begin
                bus.p1_x = 10'($urandom_range(0, 1023));
                bus.p2_x = 10'($urandom_range(0, 1023));
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (m_chk) begin
            chk("addr_valid", bus.addr_valid, exp_valid);
            if (exp_addr_chk) chk("rom_address", bus.rom_address, exp_addr);
            chk("scroll_x", bus.scroll_x, exp_scroll);
            chk("frame_done", bus.frame_done, exp_done);
            if (lit_on) chk(lit_name, bus.rom_address, lit_val);
        end
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        bus.DrawX     = 10'd0;
        bus.DrawY     = 10'd100;
        bus.blank     = 1'b0;
        bus.p1_x      = 10'd0;
        bus.p2_x      = 10'd0;
        bus.scroll_en = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_rom_address", bus.rom_address, 0);
        chk("reset_addr_valid", bus.addr_valid, 0);
        chk("reset_scroll_x", bus.scroll_x, 0);
        chk("reset_frame_done", bus.frame_done, 0);

        rst_n = 1'b1;
        m_chk = 1;
        // Reset released mid-frame: nothing valid until the coming eof
        bus.p1_x = 10'd300;
        bus.p2_x = 10'd400;
        bus.scroll_en = 1'b1;
        for (int y = 100; y < 525; y++) run_line(y);
        @(posedge clk);
        #2;
        chk("sync_frame_no_pulse", fd_cnt, 0);
        fd_cnt = 0;

        for (int f = 0; f < 26; f++) begin
            frame_no = f;
            if (f < 8) begin
                bus.p1_x = 10'd300; bus.p2_x = 10'd400; bus.scroll_en = 1'b1;
            end else if (f < 11) begin
                bus.p1_x = 10'd711; bus.p2_x = 10'd711; bus.scroll_en = 1'b0;
            end else if (f < 22) begin
                bus.p1_x = 10'd711; bus.p2_x = 10'd711; bus.scroll_en = 1'b1;
            end else if (f == 22) begin
                bus.p1_x = 10'd0; bus.p2_x = 10'd0; bus.scroll_en = 1'b1;
            end else begin
                bus.p1_x = 10'($urandom_range(0, 1023));
                bus.p2_x = 10'($urandom_range(0, 1023));
                bus.scroll_en = 1'($urandom_range(0, 1));
            end
            // Spurious eof while already running must be ignored
            if (f == 3) step(799, 524, 1'b0);
            for (int y = 0; y < 525; y++) run_line(y);
            @(posedge clk);
            #2;
            if (f <= 22) chk("scroll_after_frame", bus.scroll_x, exp_tbl[f]);
            chk("frame_done_per_frame", fd_cnt, 1);
            fd_cnt = 0;
        end

        m_chk = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_scroll_x", bus.scroll_x, 0);
        chk("async_reset_addr_valid", bus.addr_valid, 0);
        chk("async_reset_rom_address", bus.rom_address, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bg_scroll_ctrl.md
Name: bg_scroll_ctrl

Overview:
- Sequences the background-layer ROM lookup for the 640x480 VGA display.
- The background image is 712x480, stored row-major in a 19-bit-addressed ROM.
- The block generates the ROM address incrementally, with no multiplier or divider, and applies a horizontal camera offset (scroll_x) that tracks the midpoint of the two fighters.
- scroll_x is updated only during vertical blank, so no frame shows tearing.
- It sits between the VGA timing generator and the background ROM/palette pipeline.

Parameters:
- IMG_W, 712, background image width in pixels (ROM row pitch).
- SCR_W, 640, visible width.
- SCR_H, 480, visible height.
- H_TOTAL, 800, pixels per line including blanking.
- V_TOTAL, 525, lines per frame including blanking.
- STEP, 4, maximum change of scroll_x per frame, in pixels.
- ADDR_W, 19, ROM address width.
- OFF_W, 7, scroll_x width; must hold IMG_W-SCR_W (72).

Ports:
- vga_clk, input, 1, pixel clock; all logic is on the rising edge.
- reset_n, input, 1, asynchronous, active-low reset.
- DrawX, input, 10, current pixel column (0..H_TOTAL-1).
- DrawY, input, 10, current line (0..V_TOTAL-1).
- blank, input, 1, 1 = active video region.
- p1_x, input, 10, fighter 1 world x position (0..IMG_W-1).
- p2_x, input, 10, fighter 2 world x position (0..IMG_W-1).
- scroll_en, input, 1, 1 = camera may move this frame.
- rom_address, output, ADDR_W, background ROM address, registered.
- addr_valid, output, 1, rom_address corresponds to an active pixel of a synchronised frame.
- scroll_x, output, OFF_W, current camera offset.
- frame_done, output, 1, one-cycle pulse when scroll_x has been updated for the next frame.

Behaviour:
- Reset values: rom_address=0, addr_valid=0, scroll_x=0, frame_done=0, row_base=0, target=0, state=S_SYNC.
- Define eof = (DrawX==H_TOTAL-1 && DrawY==V_TOTAL-1).
- Define vbs = (DrawX==0 && DrawY==SCR_H).
- FSM states and transitions:
  - S_SYNC: addr_valid forced 0. On eof: row_base<=0, go to S_RUN.
  - S_RUN: on vbs, latch p1_x and p2_x (each clamped to IMG_W-1), go to S_CALC.
  - S_CALC (1 cycle):
    - sum = p1+p2, 11 bits, with no overflow loss.
    - mid = sum>>1.
    - t = (mid < SCR_W/2) ? 0 : mid-SCR_W/2.
    - target = min(t, IMG_W-SCR_W).
    - Go to S_MOVE.
  - S_MOVE (1 cycle):
    - If scroll_en: scroll_x moves toward target by min(STEP, |target-scroll_x|).
    - If scroll_en is low: scroll_x holds.
    - frame_done=1 this cycle regardless of scroll_en.
    - Go to S_WAIT.
  - S_WAIT: on eof, go to S_RUN.
- Row base update (every state except S_SYNC), at DrawX==H_TOTAL-1:
  - If DrawY==V_TOTAL-1: row_base<=0.
  - Else if DrawY<SCR_H-1: row_base<=row_base+IMG_W.
  - Otherwise: hold.
- Invariant: during active line y, row_base == y*IMG_W.
- Address path, 1-cycle latency:
  - rom_address <= row_base + scroll_x + DrawX, truncated to ADDR_W.
  - addr_valid <= blank && state!=S_SYNC.
  - When blank is low, rom_address still updates but addr_valid=0.
- scroll_x never changes while DrawY<SCR_H. It is stable for an entire visible frame.
- Worst-case address: 479*712+72+639 = 341759 < 2^19, so there is no wrap.
- Reset mid-frame: return to S_SYNC immediately. Addresses are invalid until the next eof. scroll_x restarts at 0.
- eof and vbs cannot coincide. An eof arriving in S_RUN without a prior vbs (timing glitch) is ignored; the state stays S_RUN.
- target==scroll_x: no change, and frame_done still pulses.

Test Plan:
- Reset released mid-frame (DrawY=100) -> addr_valid stays 0 until after eof; the first valid pixel (0,0) yields rom_address=0.
- p1_x=300, p2_x=400, scroll_en=1, start scroll_x=0 -> target=30. scroll_x steps 4,8,...,28,30 over 8 frames, with frame_done pulsing once per frame at DrawY=480.
- p1_x=p2_x=711 -> target clamps to 72. p1_x=p2_x=0 -> target=0. No underflow.
- scroll_x=72, pixel (DrawX=639, DrawY=479) -> rom_address=341759 one cycle later, addr_valid=1.
- scroll_en=0 with target≠scroll_x -> scroll_x unchanged across 3 frames, frame_done still pulses each frame.
- Pixel (DrawX=5, DrawY=1), scroll_x=20 -> rom_address=737. During blank=0, addr_valid=0.
